fetch_pair_buffer: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the TCM instruction port and consumes its 64-bit instruction pairs.
- Generates sequential 8-byte-aligned fetch addresses on the mem_i_* request interface.
- Tracks in-flight reads and buffers returned pairs with their PC in an in-order FIFO, then presents them to decode with a valid/accept handshake.
- Handles branch redirects by flushing buffered and in-flight data; handles fetch errors by halting until the next redirect.

---
 rtl/fetch_pair_buffer.sv | 111 +++++++++++
 tb/tb_fetch_pair_buffer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pair_buffer.sv
// fetch_pair_buffer: sequential 64-bit pair fetch with in-order buffering, redirect flush and fault halt
module fetch_pair_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_request_i,
    input  logic [31:0] branch_pc_i,
    input  logic        fetch_accept_i,
    output logic        fetch_valid_o,
    output logic [63:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    output logic        fetch_fault_o,
    output logic        mem_i_rd_o,
    output logic [31:0] mem_i_pc_o,
    input  logic        mem_i_accept_i,
    input  logic        mem_i_valid_i,
    input  logic        mem_i_error_i,
    input  logic [63:0] mem_i_inst_i
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] RUN = 2'd0, DROP = 2'd1, HALT = 2'd2;
    logic [1:0] state_q, state_n;
    logic [31:0] pc_q;
    logic skip_lo_q;
    logic [CW-1:0] count_q, out_q, drop_q, drop_n;
    logic [AW-1:0] rq_wr_q, rq_rd_q, dq_wr_q, dq_rd_q;
    logic [28:0] rq_pc [DEPTH];
    logic rq_skip [DEPTH];
    logic [63:0] dq_instr [DEPTH];
    logic [31:0] dq_pc [DEPTH];
    logic dq_err [DEPTH];
    logic issue, keep, push, pop;
    assign mem_i_rd_o = !rst_i && state_q == RUN && !branch_request_i &&
                        ({1'b0, count_q} + {1'b0, out_q} < (CW+1)'(DEPTH));
    assign mem_i_pc_o = pc_q;
    assign issue = mem_i_rd_o && mem_i_accept_i;
    assign keep = mem_i_valid_i && drop_q == '0;
    assign push = keep && state_q == RUN && !branch_request_i;
    assign pop = fetch_valid_o && fetch_accept_i && !branch_request_i;
    assign drop_n = out_q - CW'(mem_i_valid_i);
    assign fetch_valid_o = count_q != '0;
    assign fetch_instr_o = dq_instr[dq_rd_q];
    assign fetch_pc_o = dq_pc[dq_rd_q];
    assign fetch_fault_o = fetch_valid_o && dq_err[dq_rd_q];
    // A same-cycle response is discarded on redirect, so it is netted out of drop
    always_comb
        state_n = branch_request_i ? (drop_n != '0 ? DROP : RUN)
                : (state_q == DROP && mem_i_valid_i && drop_q == CW'(1)) ? RUN
                : (push && mem_i_error_i) ? HALT : state_q;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state_q <= RUN;
            pc_q <= RESET_PC;
            skip_lo_q <= 1'b0;
            count_q <= '0;
            out_q <= '0;
            drop_q <= '0;
            rq_wr_q <= '0;
            rq_rd_q <= '0;
            dq_wr_q <= '0;
            dq_rd_q <= '0;
        end else begin
            assert (!mem_i_valid_i || out_q != '0);
            state_q <= state_n;
            out_q <= out_q + CW'(issue) - CW'(mem_i_valid_i);
            if (branch_request_i) begin
                pc_q <= {branch_pc_i[31:3], 3'b000};
                skip_lo_q <= branch_pc_i[2];
                drop_q <= drop_n;
                count_q <= '0;
                rq_wr_q <= '0;
                rq_rd_q <= '0;
                dq_wr_q <= '0;
                dq_rd_q <= '0;
            end else begin
                if (issue) begin
                    pc_q <= pc_q + 32'd8;
                    skip_lo_q <= 1'b0;
                    rq_wr_q <= rq_wr_q + 1'b1;
                end
                if (mem_i_valid_i && drop_q != '0) drop_q <= drop_q - 1'b1;
                if (keep) rq_rd_q <= rq_rd_q + 1'b1;
                if (push) dq_wr_q <= dq_wr_q + 1'b1;
                if (pop) dq_rd_q <= dq_rd_q + 1'b1;
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                rq_pc[i] <= '0;
                rq_skip[i] <= 1'b0;
                dq_instr[i] <= '0;
                dq_pc[i] <= '0;
                dq_err[i] <= 1'b0;
            end
        end else begin
            if (issue) begin
                rq_pc[rq_wr_q] <= pc_q[31:3];
                rq_skip[rq_wr_q] <= skip_lo_q;
            end
            if (push) begin
                dq_instr[dq_wr_q] <= mem_i_inst_i;
                dq_pc[dq_wr_q] <= {rq_pc[rq_rd_q], rq_skip[rq_rd_q], 2'b00};
                dq_err[dq_wr_q] <= mem_i_error_i;
            end
        end
endmodule

// File: tb/tb_fetch_pair_buffer.sv
// tb_fetch_pair_buffer: directed scenarios plus randomized run against an instruction-stream model
module tb_fetch_pair_buffer;
    logic clk_i = 0, rst_i = 1, branch_request_i = 0, fetch_accept_i = 0;
    logic [31:0] branch_pc_i = '0;
    logic fetch_valid_o, fetch_fault_o, mem_i_rd_o;
    logic [63:0] fetch_instr_o;
    logic [31:0] fetch_pc_o, mem_i_pc_o;
    logic mem_i_accept_i = 1, mem_i_valid_i, mem_i_error_i;
    logic [63:0] mem_i_inst_i;
    int passed = 0, total = 0;
    bit rnd_lat = 0, err_en = 0;
    logic [31:0] err_addr = '0;
    logic [31:0] tq[$];

    fetch_pair_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .branch_request_i(branch_request_i), .branch_pc_i(branch_pc_i),
        .fetch_accept_i(fetch_accept_i), .fetch_valid_o(fetch_valid_o), .fetch_instr_o(fetch_instr_o),
        .fetch_pc_o(fetch_pc_o), .fetch_fault_o(fetch_fault_o), .mem_i_rd_o(mem_i_rd_o),
        .mem_i_pc_o(mem_i_pc_o), .mem_i_accept_i(mem_i_accept_i), .mem_i_valid_i(mem_i_valid_i),
        .mem_i_error_i(mem_i_error_i), .mem_i_inst_i(mem_i_inst_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [63:0] pair(input logic [31:0] a);
        return {32'hC0DE_0000 ^ (a + 32'd4), 32'h1234_0000 ^ a};
    endfunction

    // In-order TCM: responds to accepted requests after one or more cycles
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tq.delete();
            mem_i_valid_i <= 1'b0;
            mem_i_error_i <= 1'b0;
            mem_i_inst_i <= '0;
        end else begin
            if (mem_i_valid_i) void'(tq.pop_front());
            if (mem_i_rd_o && mem_i_accept_i) tq.push_back(mem_i_pc_o);
            if (tq.size() != 0 && (!rnd_lat || $urandom_range(1, 0) == 1)) begin
                mem_i_valid_i <= 1'b1;
                mem_i_inst_i <= pair(tq[0]);
                mem_i_error_i <= err_en && tq[0] == err_addr;
            end else
                mem_i_valid_i <= 1'b0;
        end
    end

    task automatic reset_dut(input logic fa);
        @(negedge clk_i);
        rst_i = 1; branch_request_i = 0; fetch_accept_i = fa; mem_i_accept_i = 1;
        @(negedge clk_i);
        rst_i = 0;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_i = 1; branch_request_i = 0; fetch_accept_i = 1; mem_i_accept_i = 1;
        #1;
        total++; if (fetch_valid_o !== 1'b0) $display("FAIL reset_valid got=%b want=0", fetch_valid_o); else passed++;
        total++; if (mem_i_rd_o !== 1'b0) $display("FAIL reset_rd got=%b want=0", mem_i_rd_o); else passed++;
        total++; if (mem_i_pc_o !== 32'h0) $display("FAIL reset_mem_pc got=%h want=0", mem_i_pc_o); else passed++;
        total++; if (fetch_fault_o !== 1'b0) $display("FAIL reset_fault got=%b want=0", fetch_fault_o); else passed++;
        @(negedge clk_i);
        rst_i = 0;
        #1;
        total++; if (mem_i_rd_o !== 1'b1 || mem_i_pc_o !== 32'h0) $display("FAIL first_req rd=%b pc=%h want rd=1 pc=0", mem_i_rd_o, mem_i_pc_o); else passed++;
        @(negedge clk_i);
        total++; if (fetch_valid_o !== 1'b0) $display("FAIL latency_early valid=%b want=0", fetch_valid_o); else passed++;
        @(negedge clk_i);
        total++; if (fetch_valid_o !== 1'b1 || fetch_pc_o !== 32'h0 || fetch_instr_o !== pair(32'h0))
            $display("FAIL latency_first valid=%b pc=%h instr=%h want valid=1 pc=0 instr=%h", fetch_valid_o, fetch_pc_o, fetch_instr_o, pair(32'h0));
        else passed++;
    endtask

    task automatic test_stream();
        reset_dut(1);
        @(negedge clk_i);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            total++;
            if (fetch_valid_o !== 1'b1 || fetch_pc_o !== 32'(8 * k) || fetch_instr_o !== pair(32'(8 * k)) || mem_i_pc_o !== 32'(8 * (k + 2)))
                $display("FAIL stream k=%0d valid=%b pc=%h mem_pc=%h want pc=%h mem_pc=%h", k, fetch_valid_o, fetch_pc_o, mem_i_pc_o, 32'(8 * k), 32'(8 * (k + 2)));
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp = 32'h8;
        reset_dut(0);
        repeat (8) @(negedge clk_i);
        total++;
        if (fetch_valid_o !== 1'b1 || fetch_pc_o !== 32'h0 || mem_i_rd_o !== 1'b0 || mem_i_pc_o !== 32'h20)
            $display("FAIL full_stall valid=%b pc=%h rd=%b mem_pc=%h want 1/0/0/20", fetch_valid_o, fetch_pc_o, mem_i_rd_o, mem_i_pc_o);
        else passed++;
        fetch_accept_i = 1;
        @(negedge clk_i);
        total++; if (mem_i_rd_o !== 1'b1 || mem_i_pc_o !== 32'h20) $display("FAIL resume_issue rd=%b mem_pc=%h want 1/20", mem_i_rd_o, mem_i_pc_o); else passed++;
        for (int c = 0; c < 40 && exp != 32'h40; c++) begin
            if (c != 0) @(negedge clk_i);
            if (fetch_valid_o) begin
                total++;
                if (fetch_pc_o !== exp || fetch_instr_o !== pair(exp)) $display("FAIL drain pc=%h instr=%h want pc=%h", fetch_pc_o, fetch_instr_o, exp);
                else passed++;
                exp += 32'h8;
            end
        end
        total++; if (exp !== 32'h40) $display("FAIL drain_timeout reached=%h want=40", exp); else passed++;
    endtask

    task automatic test_redirect();
        logic [31:0] exp = 32'h104;
        int got = 0;
        reset_dut(0);
        repeat (4) @(negedge clk_i);
        total++; if (mem_i_rd_o !== 1'b0 || fetch_pc_o !== 32'h0) $display("FAIL pre_redirect rd=%b pc=%h want 0/0", mem_i_rd_o, fetch_pc_o); else passed++;
        branch_request_i = 1; branch_pc_i = 32'h0000_0104; fetch_accept_i = 1;
        #1;
        total++; if (mem_i_rd_o !== 1'b0) $display("FAIL redirect_no_issue rd=%b want=0", mem_i_rd_o); else passed++;
        @(negedge clk_i);
        branch_request_i = 0;
        total++; if (fetch_valid_o !== 1'b0) $display("FAIL redirect_flush valid=%b want=0", fetch_valid_o); else passed++;
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(negedge clk_i);
            if (fetch_valid_o) begin
                total++;
                if (fetch_pc_o !== exp || fetch_instr_o !== pair(exp & ~32'h7) || fetch_fault_o !== 1'b0)
                    $display("FAIL redirect_data pc=%h instr=%h fault=%b want pc=%h instr=%h", fetch_pc_o, fetch_instr_o, fetch_fault_o, exp, pair(exp & ~32'h7));
                else passed++;
                exp = (exp & ~32'h7) + 32'h8; got++;
            end
        end
        total++; if (got != 2) $display("FAIL redirect_timeout got=%0d want=2", got); else passed++;
    endtask

    task automatic test_error();
        logic [31:0] exp = 32'h0;
        int got = 0;
        bit bad = 0;
        err_en = 1; err_addr = 32'h10;
        reset_dut(1);
        for (int c = 0; c < 20 && got < 3; c++) begin
            @(negedge clk_i);
            if (fetch_valid_o) begin
                total++;
                if (fetch_pc_o !== exp || fetch_fault_o !== (exp == 32'h10))
                    $display("FAIL err_stream pc=%h fault=%b want pc=%h fault=%b", fetch_pc_o, fetch_fault_o, exp, exp == 32'h10);
                else passed++;
                exp += 32'h8; got++;
            end
        end
        total++; if (got != 3) $display("FAIL err_timeout got=%0d want=3", got); else passed++;
        repeat (6) begin
            @(negedge clk_i);
            if (fetch_valid_o || mem_i_rd_o) bad = 1;
        end
        total++; if (bad) $display("FAIL halt_quiet saw valid or rd got=1 want=0"); else passed++;
        branch_request_i = 1; branch_pc_i = 32'h40;
        @(negedge clk_i);
        branch_request_i = 0;
        exp = 32'h40; got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(negedge clk_i);
            if (fetch_valid_o) begin
                total++;
                if (fetch_pc_o !== exp || fetch_fault_o !== 1'b0 || fetch_instr_o !== pair(exp))
                    $display("FAIL err_resume pc=%h fault=%b want pc=%h fault=0", fetch_pc_o, fetch_fault_o, exp);
                else passed++;
                exp += 32'h8; got++;
            end
        end
        total++; if (got != 2) $display("FAIL err_resume_timeout got=%0d want=2", got); else passed++;
        err_en = 0;
    endtask

    task automatic test_stall_redirect();
        logic [31:0] exp = 32'h80;
        int got = 0;
        reset_dut(0);
        @(negedge clk_i);
        mem_i_accept_i = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            total++; if (mem_i_pc_o !== 32'h8 || mem_i_rd_o !== 1'b1) $display("FAIL accept_stall k=%0d mem_pc=%h rd=%b want 8/1", k, mem_i_pc_o, mem_i_rd_o); else passed++;
        end
        mem_i_accept_i = 1;
        repeat (4) @(negedge clk_i);
        total++; if (fetch_valid_o !== 1'b1 || fetch_pc_o !== 32'h0) $display("FAIL stall_buffer valid=%b pc=%h want 1/0", fetch_valid_o, fetch_pc_o); else passed++;
        branch_request_i = 1; branch_pc_i = 32'h80; fetch_accept_i = 1;
        @(negedge clk_i);
        branch_request_i = 0;
        total++; if (fetch_valid_o !== 1'b0) $display("FAIL redirect_pop_flush valid=%b want=0", fetch_valid_o); else passed++;
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(negedge clk_i);
            if (fetch_valid_o) begin
                total++;
                if (fetch_pc_o !== exp || fetch_instr_o !== pair(exp)) $display("FAIL redirect_pop pc=%h want=%h", fetch_pc_o, exp);
                else passed++;
                exp += 32'h8; got++;
            end
        end
        total++; if (got != 2) $display("FAIL redirect_pop_timeout got=%0d want=2", got); else passed++;
    endtask

    task automatic test_async_reset();
        logic [31:0] exp = 32'h0;
        int got = 0;
        reset_dut(1);
        repeat (5) @(negedge clk_i);
        @(posedge clk_i);
        #3 rst_i = 1;
        #1;
        total++; if (fetch_valid_o !== 1'b0) $display("FAIL async_valid got=%b want=0", fetch_valid_o); else passed++;
        total++; if (mem_i_rd_o !== 1'b0) $display("FAIL async_rd got=%b want=0", mem_i_rd_o); else passed++;
        @(negedge clk_i);
        rst_i = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(negedge clk_i);
            if (fetch_valid_o) begin
                total++;
                if (fetch_pc_o !== exp || fetch_instr_o !== pair(exp)) $display("FAIL async_restart pc=%h want=%h", fetch_pc_o, exp);
                else passed++;
                exp += 32'h8; got++;
            end
        end
        total++; if (got != 2) $display("FAIL async_restart_timeout got=%0d want=2", got); else passed++;
    endtask

    // Model: output is the sequential pair stream from the last redirect target, cut off after a fault
    task automatic test_random();
        logic [31:0] exp = 32'h0, blk;
        bit halted = 0, br;
        int pops = 0;
        err_en = 1; err_addr = 32'($urandom_range(63, 0)) << 3;
        rnd_lat = 1;
        reset_dut(0);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            br = $urandom_range(31, 0) == 0;
            branch_request_i = br;
            if (br) branch_pc_i = 32'($urandom_range(127, 0)) << 2;
            fetch_accept_i = $urandom_range(2, 0) != 0;
            mem_i_accept_i = $urandom_range(3, 0) != 0;
            blk = exp & ~32'h7;
            if (halted) begin
                total++; if (fetch_valid_o !== 1'b0) $display("FAIL rand_halt valid=%b want=0", fetch_valid_o); else passed++;
            end else if (fetch_valid_o && fetch_accept_i && !br) begin
                total++;
                if (fetch_pc_o !== exp || fetch_instr_o !== pair(blk) || fetch_fault_o !== (err_en && blk == err_addr))
                    $display("FAIL rand_pop pc=%h instr=%h fault=%b want pc=%h instr=%h fault=%b", fetch_pc_o, fetch_instr_o, fetch_fault_o, exp, pair(blk), err_en && blk == err_addr);
                else passed++;
                if (blk == err_addr) halted = 1;
                exp = blk + 32'h8; pops++;
            end
            if (br) begin
                exp = branch_pc_i & ~32'h3;
                halted = 0;
            end
        end
        total++; if (pops < 200) $display("FAIL rand_progress pops=%0d want>=200", pops); else passed++;
        @(negedge clk_i);
        branch_request_i = 0; fetch_accept_i = 1; mem_i_accept_i = 1; rnd_lat = 0; err_en = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_error();
        test_stall_redirect();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
